// File: rtl/instruction_sender_pkg.sv
// TitanComms protocol constants shared by the instruction sender and its byte pacer.
// Opcode encodings, frame lengths, readback sequence and sender state encoding.
package instruction_sender_pkg;

    typedef enum logic [7:0] {
        OP_WRITE          = 8'h01,
        OP_READ           = 8'h02,
        OP_BIND_INTERRUPT = 8'h03,
        OP_BIND_ADDRESS   = 8'h04,
        OP_TRANSFER       = 8'h05,
        OP_REPEAT         = 8'h06
    } opcode_t;

    localparam logic [3:0] WRITE_FRAME_BYTES   = 4'd8;
    localparam logic [3:0] SHORT_FRAME_BYTES   = 4'd4;
    localparam logic [3:0] READBACK_EXCHANGES  = 4'd6;
    localparam logic [3:0] READBACK_FIRST_DATA = 4'd3;

    // Exchanges still outstanding (including the current one) when data starts arriving.
    localparam logic [3:0] READBACK_DATA_CNT = READBACK_EXCHANGES - READBACK_FIRST_DATA + 4'd1;

    localparam logic [47:0] READBACK_SEQ = {OP_REPEAT, OP_TRANSFER, OP_TRANSFER,
                                            OP_TRANSFER, OP_TRANSFER, OP_REPEAT};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RX,
        ST_GAP,
        ST_DONE
    } sender_state_t;

endpackage

// File: rtl/instruction_sender_spi_byte_pacer.sv
// Runs one SPI byte exchange at a time: launches byte_dat, reports completion with the rx byte.
// Latency: tx_valid one cycle after byte_vld & spi_tx_ready; byte_done combinational on spi_rx_valid.
// Backpressure: waits indefinitely in SEND while spi_tx_ready is low (optional GAP via INSTRUCTION_SENDER_GAP_EN).
module spi_byte_pacer
    import instruction_sender_pkg::*;
`ifdef INSTRUCTION_SENDER_GAP_EN
#(
    parameter int GAP_CYCLES = 4
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_vld,
    input  logic [7:0] byte_dat,
    output logic       byte_done,
    output logic [7:0] rx_dat,
    output logic       spi_tx_valid,
    output logic [7:0] spi_tx_byte,
    input  logic       spi_tx_ready,
    input  logic       spi_rx_valid,
    input  logic [7:0] spi_rx_byte
);

    sender_state_t state;

`ifdef INSTRUCTION_SENDER_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_cnt;
`endif

    assign byte_done = (state == ST_WAIT_RX) && spi_rx_valid;
    assign rx_dat    = spi_rx_byte;

    // SEND doubles as the rest state: the frame sequencer gates launches with byte_vld.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_SEND;
            spi_tx_valid <= 1'b0;
            spi_tx_byte  <= 8'h00;
`ifdef INSTRUCTION_SENDER_GAP_EN
            gap_cnt      <= '0;
`endif
        end else begin
            spi_tx_valid <= 1'b0;
            case (state)
                ST_SEND: begin
                    if (byte_vld && spi_tx_ready) begin
                        spi_tx_valid <= 1'b1;
                        spi_tx_byte  <= byte_dat;
                        state        <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    if (spi_rx_valid) begin
`ifdef INSTRUCTION_SENDER_GAP_EN
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= ST_GAP;
`else
                        state   <= ST_SEND;
`endif
                    end
                end
`ifdef INSTRUCTION_SENDER_GAP_EN
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
`endif
                default: state <= ST_SEND;
            endcase
        end
    end

endmodule

// File: rtl/instruction_sender.sv
// TitanComms host initiator: serialises one command into SPI bytes, READ adds the readback run.
// Latency: one exchange per byte + 1 cycle between bytes; 1 DONE cycle between frames.
// Backpressure: cmd_ready low while a frame is in flight; stalls on spi_tx_ready (INSTRUCTION_SENDER_GAP_EN adds gaps).
module instruction_sender
    import instruction_sender_pkg::*;
#(
`ifdef INSTRUCTION_SENDER_GAP_EN
    parameter int GAP_CYCLES        = 4,
`endif
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] cmd_opcode,
    input  logic [ADDRESS_WIDTH-1:0]     cmd_address,
    input  logic [VALUE_WIDTH-1:0]       cmd_value,
    output logic                         cmd_error,
    output logic                         rsp_valid,
    output logic [VALUE_WIDTH-1:0]       rsp_value,
    output logic                         busy,
    output logic                         spi_tx_valid,
    output logic [7:0]                   spi_tx_byte,
    input  logic                         spi_tx_ready,
    input  logic                         spi_rx_valid,
    input  logic [7:0]                   spi_rx_byte
);

    localparam int FRAME_W = 8 + ADDRESS_WIDTH + VALUE_WIDTH;

    sender_state_t      state;
    logic [FRAME_W-1:0] shift_reg;
    logic [3:0]         byte_cnt;
    logic               is_read;
    logic               in_rb;
    logic               byte_done;
    logic [7:0]         rx_dat;
    logic               rx_keep;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rx_keep   = in_rb && (byte_cnt <= READBACK_DATA_CNT);

    spi_byte_pacer
`ifdef INSTRUCTION_SENDER_GAP_EN
    #(.GAP_CYCLES(GAP_CYCLES))
`endif
    u_pacer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_vld     (state == ST_SEND),
        .byte_dat     (shift_reg[FRAME_W-1 -: 8]),
        .byte_done    (byte_done),
        .rx_dat       (rx_dat),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_byte  (spi_rx_byte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            byte_cnt  <= 4'd0;
            is_read   <= 1'b0;
            in_rb     <= 1'b0;
            cmd_error <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_value <= '0;
        end else begin
            cmd_error <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_read <= 1'b0;
                        in_rb   <= 1'b0;
                        case (cmd_opcode[7:0])
                            OP_WRITE: begin
                                shift_reg <= {cmd_opcode[7:0], cmd_address, cmd_value};
                                byte_cnt  <= WRITE_FRAME_BYTES;
                                state     <= ST_SEND;
                            end
                            OP_READ: begin
                                shift_reg <= {cmd_opcode[7:0], cmd_address, {VALUE_WIDTH{1'b0}}};
                                byte_cnt  <= SHORT_FRAME_BYTES;
                                is_read   <= 1'b1;
                                state     <= ST_SEND;
                            end
                            OP_BIND_INTERRUPT, OP_BIND_ADDRESS: begin
                                shift_reg <= {cmd_opcode[7:0], cmd_address, {VALUE_WIDTH{1'b0}}};
                                byte_cnt  <= SHORT_FRAME_BYTES;
                                state     <= ST_SEND;
                            end
                            default: cmd_error <= 1'b1;
                        endcase
                    end
                end
                ST_SEND: begin
                    if (byte_done) begin
                        // Readback data bytes enter at the bottom and climb into the low word.
                        shift_reg <= {shift_reg[FRAME_W-9:0], rx_keep ? rx_dat : 8'h00};
                        byte_cnt  <= byte_cnt - 4'd1;
                        if (byte_cnt == 4'd1) begin
                            if (is_read && !in_rb) begin
                                in_rb     <= 1'b1;
                                shift_reg <= {READBACK_SEQ, {(FRAME_W-48){1'b0}}};
                                byte_cnt  <= READBACK_EXCHANGES;
                            end else begin
                                state <= ST_DONE;
                                if (is_read) begin
                                    rsp_valid <= 1'b1;
                                    rsp_value <= {shift_reg[VALUE_WIDTH-9:0], rx_dat};
                                end
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sender.sv
// Directed bench for instruction_sender with a behavioural SPI master/slave.
// Expected bytes and values are hand-computed from the TitanComms frame layout.
module tb_instruction_sender;

    localparam logic [7:0] OPC_WRITE    = 8'h01;
    localparam logic [7:0] OPC_READ     = 8'h02;
    localparam logic [7:0] OPC_BIND_ADR = 8'h04;
    localparam logic [7:0] OPC_TRANSFER = 8'h05;
    localparam logic [7:0] OPC_REPEAT   = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [23:0] cmd_address = 24'h0;
    logic [31:0] cmd_value = 32'h0;
    logic        cmd_error;
    logic        rsp_valid;
    logic [31:0] rsp_value;
    logic        busy;
    logic        spi_tx_valid;
    logic [7:0]  spi_tx_byte;
    logic        spi_tx_ready;
    logic        spi_rx_valid;
    logic [7:0]  spi_rx_byte;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic       tx_busy[$];
    int         rx_log[$];
    logic [7:0] reply_tbl[16];
    int         reply_base = 0;
    int         rsp_cnt = 0;
    int         err_cnt = 0;
    logic [31:0] rsp_seen = 32'h0;
    logic [7:0]  exp_q[$];

    instruction_sender dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_address  (cmd_address),
        .cmd_value    (cmd_value),
        .cmd_error    (cmd_error),
        .rsp_valid    (rsp_valid),
        .rsp_value    (rsp_value),
        .busy         (busy),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_byte  (spi_rx_byte)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master + slave reply model: 3-cycle exchange, replies from reply_tbl.
    initial begin
        int xfer;
        int idx;
        xfer = 0;
        spi_tx_ready = 1'b1;
        spi_rx_valid = 1'b0;
        spi_rx_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xfer = 0;
                spi_rx_valid = 1'b0;
                spi_tx_ready = 1'b1;
            end else if (spi_rx_valid) begin
                spi_rx_valid = 1'b0;
                spi_tx_ready = 1'b1;
            end else if (xfer > 0) begin
                xfer--;
                if (xfer == 0) begin
                    idx = rx_log.size() - reply_base;
                    spi_rx_byte  = (idx >= 0 && idx < 16) ? reply_tbl[idx] : 8'h00;
                    spi_rx_valid = 1'b1;
                    rx_log.push_back(cyc);
                end
            end else if (spi_tx_valid) begin
                tx_log.push_back(spi_tx_byte);
                tx_cyc.push_back(cyc);
                tx_busy.push_back(busy);
                spi_tx_ready = 1'b0;
                xfer = 3;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_seen = rsp_value;
            end
            if (cmd_error) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [23:0] adr, input logic [31:0] val);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_opcode  = op;
        cmd_address = adr;
        cmd_value   = val;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 64'(n < 1000), 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < 1000), 64'd1);
    endtask

    task automatic chk_frame(input string tag, input int base);
        chk({tag, "_count"}, 64'(tx_log.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < tx_log.size())
                chk($sformatf("%s_byte%0d", tag, i), 64'(tx_log[base + i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        int tb0;
        int rb0;
        int rs0;
        int er0;
        int n;
        int gmin;
        int gmax;
        int g;
        int low_cnt;
        logic all_busy;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tx_valid", 64'(spi_tx_valid), 64'd0);
        chk("rst_tx_byte", 64'(spi_tx_byte), 64'd0);
        chk("rst_rsp_value", 64'(rsp_value), 64'd0);
        chk("rst_cmd_error", 64'(cmd_error), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // WRITE
        tb0 = tx_log.size();
        rs0 = rsp_cnt;
        send_cmd(OPC_WRITE, 24'h000010, 32'hDEADBEEF);
        wait_idle("write_done");
        repeat (3) @(negedge clk);
        exp_q = '{OPC_WRITE, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        chk_frame("write", tb0);
        chk("write_no_rsp", 64'(rsp_cnt - rs0), 64'd0);
        chk("write_ready", 64'(cmd_ready), 64'd1);

        // READ with readback
        reply_tbl = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'hC3, 8'h12, 8'h34,
                      8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        reply_base = rx_log.size();
        tb0 = tx_log.size();
        rb0 = rx_log.size();
        rs0 = rsp_cnt;
        send_cmd(OPC_READ, 24'h000020, 32'hFFFFFFFF);
        wait_idle("read_done");
        repeat (3) @(negedge clk);
        exp_q = '{OPC_READ, 8'h00, 8'h00, 8'h20, OPC_REPEAT,
                  OPC_TRANSFER, OPC_TRANSFER, OPC_TRANSFER, OPC_TRANSFER, OPC_REPEAT};
        chk_frame("read", tb0);
        chk("read_rsp_count", 64'(rsp_cnt - rs0), 64'd1);
        chk("read_rsp_pulse_value", 64'(rsp_seen), 64'h12345678);
        chk("read_rsp_held", 64'(rsp_value), 64'h12345678);
        gmin = 1000;
        gmax = 0;
        for (int i = 1; i < 10; i++) begin
            if (tb0 + i < tx_cyc.size() && rb0 + i - 1 < rx_log.size()) begin
                g = tx_cyc[tb0 + i] - rx_log[rb0 + i - 1] - 1;
                if (g < gmin) gmin = g;
                if (g > gmax) gmax = g;
            end
        end
`ifdef INSTRUCTION_SENDER_GAP_EN
        chk("gap_min_ge5", 64'(gmin >= 5), 64'd1);
`else
        chk("gap_min", 64'(gmin), 64'd1);
        chk("gap_max", 64'(gmax), 64'd1);
`endif

        // BIND_ADDRESS
        tb0 = tx_log.size();
        send_cmd(OPC_BIND_ADR, 24'hABCDEF, 32'h0);
        wait_idle("bind_done");
        @(negedge clk);
        exp_q = '{OPC_BIND_ADR, 8'hAB, 8'hCD, 8'hEF};
        chk_frame("bind", tb0);
        all_busy = 1'b1;
        for (int i = tb0; i < tx_busy.size(); i++) all_busy &= tx_busy[i];
        chk("bind_busy_during", 64'(all_busy), 64'd1);
        chk("bind_busy_after", 64'(busy), 64'd0);

        // Unsupported opcode
        tb0 = tx_log.size();
        er0 = err_cnt;
        send_cmd(OPC_TRANSFER, 24'h000001, 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (!cmd_ready) low_cnt++;
            @(negedge clk);
        end
        chk("bad_op_error_pulses", 64'(err_cnt - er0), 64'd1);
        chk("bad_op_no_tx", 64'(tx_log.size() - tb0), 64'd0);
        chk("bad_op_ready_low_cycles", 64'(low_cnt), 64'd0);

        // Reset after the 3rd byte of a WRITE
        tb0 = tx_log.size();
        rb0 = rx_log.size();
        rs0 = rsp_cnt;
        send_cmd(OPC_WRITE, 24'h5A5A5A, 32'h11223344);
        n = 0;
        while (rx_log.size() - rb0 < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reach3_timeout", 64'(n < 1000), 64'd1);
        chk("midrst_tx_byte_before", 64'(spi_tx_byte), 64'h5A);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tx_valid", 64'(spi_tx_valid), 64'd0);
        chk("midrst_tx_byte", 64'(spi_tx_byte), 64'd0);
        chk("midrst_rsp_value", 64'(rsp_value), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_no_rsp", 64'(rsp_cnt - rs0), 64'd0);

        reply_tbl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h99, 8'h77, 8'hCA, 8'hFE,
                      8'hF0, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        reply_base = rx_log.size();
        tb0 = tx_log.size();
        rs0 = rsp_cnt;
        send_cmd(OPC_READ, 24'h000030, 32'h0);
        wait_idle("postrst_read_done");
        repeat (3) @(negedge clk);
        exp_q = '{OPC_READ, 8'h00, 8'h00, 8'h30, OPC_REPEAT,
                  OPC_TRANSFER, OPC_TRANSFER, OPC_TRANSFER, OPC_TRANSFER, OPC_REPEAT};
        chk_frame("postrst_read", tb0);
        chk("postrst_rsp_count", 64'(rsp_cnt - rs0), 64'd1);
        chk("postrst_rsp_value", 64'(rsp_value), 64'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
